uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ word producers, e.g. LFSR output and status sources.
- Grants one requester at a time and latches its word.
- Optionally sends a one-byte header tagging the source, then sends the word LSB-first, one UART frame per byte.
- Acknowledges the requester when the word is complete. Sits between the producers and the UART TX block (tx_start/tx_byte in, tx_active/tx_done out).

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WORD_BYTES, 4, bytes per requester word (1..8).
- HDR_EN, 1, 1 = send header byte before each word; 0 = no header.
- HDR_BASE, 8'hA0, header value. Header = HDR_BASE | grant id in bits [IDW-1:0].
- IDW is a localparam = max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester level request; held until its ack.
- req_data  in  NUM_REQ*WORD_BYTES*8  concatenated words; requester i occupies bits [i*WORD_BYTES*8 +: WORD_BYTES*8].
- ack  out  NUM_REQ  one-cycle pulse to the granted requester when its last byte's tx_done is seen.
- tx_start  out  1  one-cycle start pulse to the UART TX.
- tx_byte  out  8  byte to transmit; stable from tx_start until the next byte is loaded.
- tx_active  in  1  UART TX busy.
- tx_done  in  1  UART TX frame-complete pulse.
- busy  out  1  high from grant until the ack cycle inclusive.
- grant_id  out  IDW  id of the current/last granted requester.

Behaviour:
- All outputs are registered.
- Reset: ack=0, tx_start=0, tx_byte=0, busy=0, grant_id=0, state=IDLE, byte counter=0, RR pointer=0 (requester 0 highest priority).
- States:
  - IDLE: if any req, pick the first set bit searching from ptr upward, modulo NUM_REQ. Latch that word into the shift register, set grant_id, busy=1, byte counter=0, ptr = grant+1 mod NUM_REQ. Go to ISSUE. Otherwise stay.
  - ISSUE: when tx_active==0, assert tx_start for exactly 1 cycle. tx_byte = header if HDR_EN and counter==0, otherwise the low byte of the shift register. Go to WAIT. If tx_active==1, hold in ISSUE with tx_start=0.
  - WAIT: wait for tx_done. On tx_done, increment the counter. Shift the word right 8 only if a data byte was sent. If counter == WORD_BYTES+HDR_EN go to ACK, else go to ISSUE.
  - ACK: ack[grant_id]=1 for one cycle, busy stays 1, then IDLE with busy=0.
- Latency:
  - req sampled in IDLE at cycle 0 → tx_start high in cycle 2 at the earliest (IDLE→ISSUE edge, then the registered start).
  - Byte-to-byte gap: ISSUE re-entered the cycle after tx_done; tx_start follows once tx_active is low.
- Requester contract:
  - req_data is sampled only at grant; it may change afterward.
  - req must deassert in the cycle after ack; a registered requester meets this.
  - A re-asserted req competes normally and gets lowest priority due to the ptr advance.
- tx_done outside WAIT is ignored. tx_done in the same cycle as tx_start is ignored (WAIT not yet entered).
- Word order: header (if enabled), then byte0 = bits [7:0], …, byte WORD_BYTES-1.
- Reset mid-word:
  - Abort immediately; no ack issued; the partial word is discarded.
  - A UART frame already in flight is not cancelled by this block; the first post-reset tx_start waits for tx_active==0.
  - The requester is re-served from the header after reset.
- Simultaneous requests: resolved purely by the RR pointer; no starvation (max wait = NUM_REQ-1 words).

Test Plan:
(UART model: tx_active high from cycle after tx_start until tx_done; tx_done pulse 20 cycles after start. Defaults unless stated.)
1. Single request: req=2'b01, data0=32'h11223344 → tx_byte sequence A0,44,33,22,11; 5 tx_start pulses; one ack=2'b01 one cycle after the 5th tx_done; busy high throughout.
2. Both requesters after reset: req=2'b11, data0=32'hDEADBEEF, data1=32'h01020304 → A0,EF,BE,AD,DE then A1,04,03,02,01; grant_id 0 then 1; ack 01 then 10.
3. Fairness: req0 re-asserts immediately after every ack, req1 held high → grant order 0,1,0,1; neither requester is granted twice in a row while the other waits.
4. Start gating: tx_active forced high for 50 cycles at grant → no tx_start while high; exactly one 1-cycle tx_start the cycle after it drops. A spurious tx_done during ISSUE is ignored (counter unchanged).
5. Reset mid-word: assert rst for 1 cycle after the 2nd tx_done → all outputs 0 next cycle, no ack; with req0 still high, resend starts with A0 after tx_active clears.
6. HDR_EN=0, WORD_BYTES=1, NUM_REQ=3, req=3'b100, data2=8'h5A → single byte 5A, grant_id=2, ack=3'b100.

Source files
------------

// File: rtl/uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin scheduler sharing one UART transmitter between
//            NUM_REQ word producers. Optional source-tag header byte, then
//            the granted word LSB-byte first, one UART frame per byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int         NUM_REQ    = 2,
    parameter int         WORD_BYTES = 4,
    parameter int         HDR_EN     = 1,
    parameter logic [7:0] HDR_BASE   = 8'hA0,
    localparam int        IDW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            tx_start,
    output logic [7:0]                      tx_byte,
    input  logic                            tx_active,
    input  logic                            tx_done,
    output logic                            busy,
    output logic [IDW-1:0]                  grant_id
);

    localparam int         C_WBITS = WORD_BYTES * 8;
    localparam int         C_HDR_N = (HDR_EN != 0) ? 1 : 0;
    localparam logic [3:0] C_LAST  = 4'(WORD_BYTES + C_HDR_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_grant;
    logic [C_WBITS-1:0]   r_shift;
    logic [3:0]           r_cnt;
    logic                 r_start;
    logic [7:0]           r_byte;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_busy;

    state_t               w_state_n;
    logic [IDW-1:0]       w_ptr_n;
    logic [IDW-1:0]       w_grant_n;
    logic [C_WBITS-1:0]   w_shift_n;
    logic [3:0]           w_cnt_n;
    logic                 w_start_n;
    logic [7:0]           w_byte_n;
    logic [NUM_REQ-1:0]   w_ack_n;
    logic                 w_busy_n;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic                 w_found;
    logic [IDW-1:0]       w_pick;
    logic [IDW-1:0]       w_ptr_after;
    logic [C_WBITS-1:0]   w_word;
    logic [7:0]           w_hdr;
    logic                 w_hdr_phase;

    // Round-robin pick: rotate requests so the pointer sits at bit 0, lowest set bit wins
    always_comb begin
        w_req_dbl = {req, req};
        w_req_rot = NUM_REQ'(w_req_dbl >> r_ptr);
        w_found   = 1'b0;
        w_pick    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
        w_ptr_after = (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;
        w_word      = C_WBITS'(req_data >> (w_pick * C_WBITS));
        w_hdr       = HDR_BASE | 8'(r_grant);
        w_hdr_phase = (C_HDR_N != 0) && (r_cnt == 4'd0);
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_grant_n = r_grant;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        w_start_n = 1'b0;
        w_byte_n  = r_byte;
        w_ack_n   = '0;
        w_busy_n  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_busy_n = 1'b0;
                if (w_found) begin
                    w_grant_n = w_pick;
                    w_ptr_n   = w_ptr_after;
                    w_shift_n = w_word;
                    w_cnt_n   = 4'd0;
                    w_busy_n  = 1'b1;
                    w_state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!tx_active) begin
                    w_start_n = 1'b1;
                    w_byte_n  = w_hdr_phase ? w_hdr : r_shift[7:0];
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done coinciding with our own start pulse belongs to an older frame
                if (tx_done && !r_start) begin
                    w_cnt_n = r_cnt + 4'd1;
                    if (!w_hdr_phase) begin
                        w_shift_n = r_shift >> 8;
                    end
                    if (r_cnt + 4'd1 == C_LAST) begin
                        w_ack_n   = NUM_REQ'(1) << r_grant;
                        w_state_n = S_ACK;
                    end else begin
                        w_state_n = S_ISSUE;
                    end
                end
            end
            S_ACK: begin
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_shift <= '0;
            r_cnt   <= 4'd0;
            r_start <= 1'b0;
            r_byte  <= 8'd0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_grant <= w_grant_n;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
            r_start <= w_start_n;
            r_byte  <= w_byte_n;
            r_ack   <= w_ack_n;
            r_busy  <= w_busy_n;
        end
    end

    assign ack      = r_ack;
    assign tx_start = r_start;
    assign tx_byte  = r_byte;
    assign busy     = r_busy;
    assign grant_id = r_grant;

endmodule
`default_nettype wire
